prog_loader: RTL

- Hardware program loader for the pipeline core; the synthesizable counterpart of the bench's backdoor instruction-memory preload.
- Accepts a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes those words into instruction memory through its write port.
- Holds the core in reset (`core_rst`) until a complete, checksum-valid image has been written, then releases it so PC starts at 0.

---
 rtl/prog_loader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: takes a framed little-endian byte stream (length, words,
// checksum), writes the assembled words into instruction memory and holds
// the core in reset until a complete image with a valid checksum is loaded.
module prog_loader #(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Word counter only needs to reach DEPTH_WORDS-1; the length check
    // rejects anything larger before DATA is entered.
    localparam int CNT_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_reg;
    logic [4:0]       flags_reg;      // {in_ready, busy, done, err, core_rst}
    logic [15:0]      len_reg;
    logic [CNT_W-1:0] word_cnt_reg;
    logic [1:0]       byte_cnt_reg;
    logic [7:0]       csum_reg;
    logic [31:0]      shift_reg;

    logic             accept;
    logic [15:0]      len_next;
    logic [15:0]      word_cnt_ext;
    logic             last_word;
    logic [31:0]      word_next;
    logic [CNT_W+1:0] addr_full;
    logic [ADDR_W-1:0] addr_fit;

    // Status outputs are a registered image of the state they belong to,
    // updated on the same edge as the state transition.
    function automatic logic [4:0] flags_of(input state_t s);
        case (s)
            S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: flags_of = 5'b11001;
            S_DONE:                             flags_of = 5'b00100;
            S_ERR:                              flags_of = 5'b00011;
            default:                            flags_of = 5'b00001;
        endcase
    endfunction

    assign {in_ready, busy, done, err, core_rst} = flags_reg;

    assign accept       = in_valid && in_ready;
    assign len_next     = {in_data, len_reg[7:0]};
    assign word_cnt_ext = 16'(word_cnt_reg);
    assign last_word    = (word_cnt_ext == (len_reg - 16'd1));
    assign word_next    = {in_data, shift_reg[31:8]};
    assign addr_full    = {word_cnt_reg, 2'b00};

    // Byte address = word index * 4, zero-extended or truncated to ADDR_W.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr
            if (gi < CNT_W + 2) begin : g_bit
                assign addr_fit[gi] = addr_full[gi];
            end else begin : g_zero
                assign addr_fit[gi] = 1'b0;
            end
        end
    endgenerate

    // Frame parser, word assembly, write strobe and checksum in one FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            flags_reg    <= flags_of(S_IDLE);
            len_reg      <= '0;
            word_cnt_reg <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            shift_reg    <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_reg    <= S_LEN_LO;
                        flags_reg    <= flags_of(S_LEN_LO);
                        len_reg      <= '0;
                        word_cnt_reg <= '0;
                        byte_cnt_reg <= '0;
                        csum_reg     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_reg[7:0] <= in_data;
                        csum_reg     <= csum_reg + in_data;
                        state_reg    <= S_LEN_HI;
                        flags_reg    <= flags_of(S_LEN_HI);
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_reg[15:8] <= in_data;
                        csum_reg      <= csum_reg + in_data;
                        if (len_next > 16'(DEPTH_WORDS)) begin
                            state_reg <= S_ERR;
                            flags_reg <= flags_of(S_ERR);
                        end else if (len_next == 16'd0) begin
                            state_reg <= S_CSUM;
                            flags_reg <= flags_of(S_CSUM);
                        end else begin
                            state_reg <= S_DATA;
                            flags_reg <= flags_of(S_DATA);
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shift_reg    <= word_next;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        csum_reg     <= csum_reg + in_data;
                        if (byte_cnt_reg == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= addr_fit;
                            imem_wdata <= word_next;
                            if (last_word) begin
                                state_reg <= S_CSUM;
                                flags_reg <= flags_of(S_CSUM);
                            end else begin
                                word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (in_data == csum_reg) begin
                            state_reg <= S_DONE;
                            flags_reg <= flags_of(S_DONE);
                        end else begin
                            state_reg <= S_ERR;
                            flags_reg <= flags_of(S_ERR);
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    flags_reg <= flags_of(S_IDLE);
                end
            endcase
        end
    end

endmodule
